acc_cpu_ctrl: RTL
=================

Name: acc_cpu_ctrl

Overview:
- Multi-cycle fetch/execute controller for an accumulator machine.
- Sits directly upstream of the single-port word memory (combinational read, synchronous write, one addr/we/d_in/d_out port).
- Drives that memory's address, write-enable and write data, and consumes its read data as both instructions and operands.
- Every instruction takes exactly 2 cycles: FETCH, then EXEC.

Parameters:
- WORDSIZE, 16: memory word and accumulator width.
- ADDRSIZE, 8: memory address width and PC width. The opcode field is ir[WORDSIZE-1:ADDRSIZE].
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- run  in  1  fetch enable, sampled only in FETCH.
- mem_addr  out  ADDRSIZE  memory address; combinational from state.
- mem_we  out  1  memory write enable; combinational from state.
- mem_din  out  WORDSIZE  memory write data; always equals acc.
- mem_dout  in  WORDSIZE  memory read data; valid in the same cycle as mem_addr.
- pc  out  ADDRSIZE  program counter.
- acc  out  WORDSIZE  accumulator.
- carry  out  1  carry/borrow flag.
- out_data  out  WORDSIZE  last value emitted by OUT.
- out_valid  out  1  one-cycle strobe accompanying OUT.
- halted  out  1  controller stopped.
- illegal  out  1  stopped because of an undefined opcode.

Behaviour:
- Reset (async, any state, including mid-EXEC):
  - state=FETCH, pc=RESET_PC, ir=0, acc=0, carry=0.
  - out_data=0, out_valid=0, halted=0, illegal=0.
  - mem_we=0 immediately.
- Instruction format: opcode=ir[15:8], operand m=ir[7:0].
- States: FETCH, EXEC, HALT.
- FETCH:
  - mem_addr=pc, mem_we=0.
  - If run=1: ir<=mem_dout, pc<=pc+1 (wraps 0xFF->0x00), go to EXEC.
  - If run=0: all registers hold and state stays FETCH.
- EXEC: mem_addr=m for every opcode. Always returns to FETCH unless stated otherwise. run is ignored here; an instruction in EXEC always completes.
  - 0x00 NOP: no effect.
  - 0x01 LDA: acc<=mem_dout. carry unchanged.
  - 0x02 STA: mem_we=1 for this cycle only, mem_din=acc.
  - 0x03 ADD: {carry,acc}<=acc+mem_dout, computed at WORDSIZE+1 bits.
  - 0x04 SUB: acc<=acc-mem_dout (mod 2^WORDSIZE); carry<=1 iff acc<mem_dout (unsigned borrow).
  - 0x05 LDI: acc<=zero-extended m. carry unchanged.
  - 0x06 JMP: pc<=m.
  - 0x07 JZ: pc<=m iff acc==0; otherwise pc keeps its already-incremented value.
  - 0x08 JC: pc<=m iff carry==1.
  - 0x09 OUT: out_data<=acc, out_valid<=1. out_valid is cleared on the next edge, so it is high for exactly one cycle.
  - 0x0F HLT: go to HALT, halted<=1.
  - Any other opcode: go to HALT, halted<=1, illegal<=1. acc, pc and carry are unchanged.
- HALT:
  - mem_we=0, mem_addr=pc.
  - All registers frozen.
  - Left only via rst.
- mem_we is high only in EXEC with opcode 0x02. It is never high in FETCH, in HALT, or during reset.
- Flags: carry is modified only by ADD and SUB.
- Timing: a write issued by STA becomes visible to the FETCH of the following cycle (write on edge, combinational read).

Test Plan:
1. Basic program. mem[0]=0x0510, mem[1]=0x0320, mem[2]=0x0221, mem[3]=0x0F00, mem[0x20]=0x0005; run=1 after reset.
   - Required after 8 edges: mem[0x21]=0x0015, acc=0x0015, pc=0x04, halted=1, illegal=0.
   - Required: mem_we high in exactly one cycle.
2. Carry and JC.
   - Sequence: LDI 0xFF, ADD [0x20]=0xFF01. Required: acc=0x0000, carry=1.
   - Then JC 0x40. Required: pc=0x40.
   - Then SUB [0x41]=0x0001 with acc=0. Required: acc=0xFFFF, carry=1.
3. JZ both paths.
   - acc=0x0001, JZ 0x30 at addr 5. Required: pc=0x06.
   - acc=0, same instruction. Required: pc=0x30.
   - Program at 0xFF falls through. Required: pc wraps to 0x00.
4. OUT strobe.
   - Sequence: LDI 0x2A, OUT.
   - Required: out_valid high for exactly one cycle, out_data=0x002A, and out_data holds 0x002A afterwards.
5. Illegal opcode.
   - Fetch 0x0A00 at addr 2. Required after the EXEC edge: halted=1, illegal=1, pc=0x03.
   - Required: no further memory writes for 20 cycles.
   - Then pulse rst. Required: both flags clear and pc=0.
6. run and reset.
   - Hold run=0 for 5 cycles in FETCH. Required: pc and state unchanged, mem_we=0.
   - Assert rst asynchronously during STA's EXEC cycle. Required: mem_we drops without waiting for a clock edge, pc=0, acc=0, and the target word is unmodified.

Source files
------------

// File: rtl/acc_cpu_ctrl.sv
// Two-cycle FETCH/EXEC controller for an accumulator machine driving a
// single-port word memory with combinational read and synchronous write.
module acc_cpu_ctrl #(
    parameter int WORDSIZE = 16,
    parameter int ADDRSIZE = 8,
    parameter int RESET_PC = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    output logic [ADDRSIZE-1:0] mem_addr,
    output logic                mem_we,
    output logic [WORDSIZE-1:0] mem_din,
    input  logic [WORDSIZE-1:0] mem_dout,
    output logic [ADDRSIZE-1:0] pc,
    output logic [WORDSIZE-1:0] acc,
    output logic                carry,
    output logic [WORDSIZE-1:0] out_data,
    output logic                out_valid,
    output logic                halted,
    output logic                illegal
);

    localparam int OPW = WORDSIZE - ADDRSIZE;

    localparam logic [OPW-1:0] OP_NOP = OPW'(8'h00);
    localparam logic [OPW-1:0] OP_LDA = OPW'(8'h01);
    localparam logic [OPW-1:0] OP_STA = OPW'(8'h02);
    localparam logic [OPW-1:0] OP_ADD = OPW'(8'h03);
    localparam logic [OPW-1:0] OP_SUB = OPW'(8'h04);
    localparam logic [OPW-1:0] OP_LDI = OPW'(8'h05);
    localparam logic [OPW-1:0] OP_JMP = OPW'(8'h06);
    localparam logic [OPW-1:0] OP_JZ  = OPW'(8'h07);
    localparam logic [OPW-1:0] OP_JC  = OPW'(8'h08);
    localparam logic [OPW-1:0] OP_OUT = OPW'(8'h09);
    localparam logic [OPW-1:0] OP_HLT = OPW'(8'h0F);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDRSIZE-1:0] pc_q, pc_d;
    logic [WORDSIZE-1:0] ir_q, ir_d;
    logic [WORDSIZE-1:0] acc_q, acc_d;
    logic                carry_q, carry_d;
    logic [WORDSIZE-1:0] out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                halted_q, halted_d;
    logic                illegal_q, illegal_d;

    logic [OPW-1:0]      opcode_s;
    logic [ADDRSIZE-1:0] operand_s;
    logic [WORDSIZE:0]   sum_s;
    logic [WORDSIZE:0]   diff_s;

    function automatic logic is_legal(input logic [OPW-1:0] op);
        logic ok;
        case (op)
            OP_NOP, OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_LDI,
            OP_JMP, OP_JZ, OP_JC, OP_OUT, OP_HLT: ok = 1'b1;
            default:                              ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign opcode_s  = ir_q[WORDSIZE-1:ADDRSIZE];
    assign operand_s = ir_q[ADDRSIZE-1:0];
    // Both arithmetic results are one bit wider; the top bit is carry or borrow.
    assign sum_s     = {1'b0, acc_q} + {1'b0, mem_dout};
    assign diff_s    = {1'b0, acc_q} - {1'b0, mem_dout};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (run) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if ((opcode_s == OP_HLT) || !is_legal(opcode_s)) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
    end

    // Memory port outputs; the write strobe is also gated by rst so it drops
    // the instant reset is asserted.
    always_comb begin
        mem_addr = pc_q;
        mem_we   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_addr = pc_q;
                mem_we   = 1'b0;
            end
            ST_EXEC: begin
                mem_addr = operand_s;
                if ((opcode_s == OP_STA) && !rst) begin
                    mem_we = 1'b1;
                end else begin
                    mem_we = 1'b0;
                end
            end
            ST_HALT: begin
                mem_addr = pc_q;
                mem_we   = 1'b0;
            end
            default: begin
                mem_addr = pc_q;
                mem_we   = 1'b0;
            end
        endcase
    end

    // Datapath next-state: fetch loads IR and bumps PC, execute applies the opcode.
    always_comb begin
        pc_d        = pc_q;
        ir_d        = ir_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        halted_d    = halted_q;
        illegal_d   = illegal_q;
        case (state_q)
            ST_FETCH: begin
                if (run) begin
                    ir_d = mem_dout;
                    pc_d = pc_q + {{(ADDRSIZE-1){1'b0}}, 1'b1};
                end else begin
                    ir_d = ir_q;
                    pc_d = pc_q;
                end
            end
            ST_EXEC: begin
                case (opcode_s)
                    OP_NOP: acc_d = acc_q;
                    OP_LDA: acc_d = mem_dout;
                    OP_STA: acc_d = acc_q;
                    OP_ADD: begin
                        acc_d   = sum_s[WORDSIZE-1:0];
                        carry_d = sum_s[WORDSIZE];
                    end
                    OP_SUB: begin
                        acc_d   = diff_s[WORDSIZE-1:0];
                        carry_d = diff_s[WORDSIZE];
                    end
                    OP_LDI: acc_d = {{OPW{1'b0}}, operand_s};
                    OP_JMP: pc_d = operand_s;
                    OP_JZ: begin
                        if (acc_q == {WORDSIZE{1'b0}}) begin
                            pc_d = operand_s;
                        end else begin
                            pc_d = pc_q;
                        end
                    end
                    OP_JC: begin
                        if (carry_q) begin
                            pc_d = operand_s;
                        end else begin
                            pc_d = pc_q;
                        end
                    end
                    OP_OUT: begin
                        out_data_d  = acc_q;
                        out_valid_d = 1'b1;
                    end
                    OP_HLT: halted_d = 1'b1;
                    default: begin
                        halted_d  = 1'b1;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_HALT: begin
                pc_d = pc_q;
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= ADDRSIZE'(RESET_PC);
            ir_q        <= {WORDSIZE{1'b0}};
            acc_q       <= {WORDSIZE{1'b0}};
            carry_q     <= 1'b0;
            out_data_q  <= {WORDSIZE{1'b0}};
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
            illegal_q   <= illegal_d;
        end
    end

    assign mem_din   = acc_q;
    assign pc        = pc_q;
    assign acc       = acc_q;
    assign carry     = carry_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;

endmodule
